// File: rtl/fifo_drain_if.sv
`default_nettype none
// ============================================================================
//  Module   : fifo_drain_if
//  Brief    : FIFO read-port and packed word stream bundle for fifo_drain.
//  Revision : 1.0  initial release
// ============================================================================
interface fifo_drain_if #(
  parameter int BYTES_PER_WORD = 4
);
  logic                          fifo_empty;
  logic [7:0]                    fifo_rdata;
  logic                          fifo_ren;
  logic                          out_valid;
  logic                          out_ready;
  logic [8*BYTES_PER_WORD-1:0]   out_data;
  logic [BYTES_PER_WORD-1:0]     out_keep;

  // master = the drain engine, slave = the FIFO plus downstream sink
  modport master (
    input  fifo_empty, fifo_rdata, out_ready,
    output fifo_ren, out_valid, out_data, out_keep
  );
  modport slave (
    output fifo_empty, fifo_rdata, out_ready,
    input  fifo_ren, out_valid, out_data, out_keep
  );
endinterface
`default_nettype wire

// File: rtl/fifo_drain.sv
`default_nettype none
// ============================================================================
//  Module   : fifo_drain
//  Brief    : Pops bytes from a FIFO head and packs them little-endian into
//             words on a valid/ready stream with keep mask and flush.
//  Revision : 1.0  initial release
// ============================================================================
module fifo_drain #(
  parameter int BYTES_PER_WORD = 4,
  parameter int CNT_BITS       = 16
) (
  input  wire logic                clk,
  input  wire logic                rst_n,
  input  wire logic                flush,
  output logic [CNT_BITS-1:0]      word_count,
  fifo_drain_if.master             bus
);

  localparam int IDX_W = $clog2(BYTES_PER_WORD);
  localparam logic [IDX_W-1:0] c_last_idx = IDX_W'(BYTES_PER_WORD - 1);

  typedef enum logic [0:0] {
    FILL = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t                        r_state;
  logic [IDX_W-1:0]              r_idx;
  logic                          r_valid;
  logic [8*BYTES_PER_WORD-1:0]   r_data;
  logic [BYTES_PER_WORD-1:0]     r_keep;
  logic [CNT_BITS-1:0]           r_count;

  logic w_pop;
  logic w_to_hold;

  // rst_n gates the pop so the FIFO never sees a strobe while in reset
  assign w_pop     = (r_state == FILL) && rst_n && !bus.fifo_empty;
  assign w_to_hold = (w_pop && (r_idx == c_last_idx)) ||
                     (flush && ((r_idx != '0) || w_pop));

  assign bus.fifo_ren  = w_pop;
  assign bus.out_valid = r_valid;
  assign bus.out_data  = r_data;
  assign bus.out_keep  = r_keep;
  assign word_count    = r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= FILL;
      r_idx   <= '0;
      r_valid <= 1'b0;
      r_data  <= '0;
      r_keep  <= '0;
      r_count <= '0;
    end else begin
      case (r_state)
        FILL: begin
          if (w_pop) begin
            for (int k = 0; k < BYTES_PER_WORD; k++) begin
              if (r_idx == IDX_W'(k)) begin
                r_data[8*k +: 8] <= bus.fifo_rdata;
                r_keep[k]        <= 1'b1;
              end
            end
            r_idx <= r_idx + 1'b1;
          end
          if (w_to_hold) begin
            r_state <= HOLD;
            r_valid <= 1'b1;
          end
        end
        HOLD: begin
          // lanes clear on accept so a later flushed word reads 0 above its last byte
          if (bus.out_ready) begin
            r_state <= FILL;
            r_idx   <= '0;
            r_valid <= 1'b0;
            r_data  <= '0;
            r_keep  <= '0;
            r_count <= r_count + 1'b1;
          end
        end
        default: r_state <= FILL;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fifo_drain.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fifo_drain
//  Brief    : Directed bench for fifo_drain with a behavioural byte FIFO.
//  Revision : 1.0  initial release
// ============================================================================
module tb_fifo_drain;

  localparam int BPW = 4;
  localparam int CB  = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          flush;
  logic [CB-1:0] word_count;

  fifo_drain_if #(.BYTES_PER_WORD(BPW)) bus ();

  fifo_drain #(.BYTES_PER_WORD(BPW), .CNT_BITS(CB)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .word_count (word_count),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  logic [7:0] mem [0:255];
  int wr_ptr = 0;
  int rd_ptr = 0;
  int ren_pulses = 0;
  int underflows = 0;
  int tests = 0;
  int fails = 0;
  int exp_count = 0;

  assign bus.fifo_empty = (wr_ptr == rd_ptr);
  assign bus.fifo_rdata = mem[rd_ptr[7:0]];

  // FIFO model: strobe sampled at the edge, head advances just after it
  always @(posedge clk) begin : model
    logic popped;
    popped = bus.fifo_ren;
    #1;
    if (popped) begin
      ren_pulses++;
      if (wr_ptr == rd_ptr) underflows++;
      else rd_ptr++;
    end
  end

  task automatic push(input logic [7:0] b);
    mem[wr_ptr[7:0]] = b;
    wr_ptr++;
  endtask

  task automatic accept();
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    exp_count = (exp_count + 1) % 16;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; flush = 1'b0; bus.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    push(8'h01); push(8'h02); push(8'h03); push(8'h04);
    #1;
    tests++; if (bus.fifo_ren !== 1'b0) begin fails++; $display("FAIL rst_ren: got %b want 0", bus.fifo_ren); end
    tests++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL rst_valid: got %b want 0", bus.out_valid); end
    tests++; if (bus.out_data !== 32'h0) begin fails++; $display("FAIL rst_data: got %h want 0", bus.out_data); end
    tests++; if (bus.out_keep !== 4'h0) begin fails++; $display("FAIL rst_keep: got %h want 0", bus.out_keep); end
    tests++; if (word_count !== 4'h0) begin fails++; $display("FAIL rst_count: got %0d want 0", word_count); end
    @(negedge clk);
    tests++; if (ren_pulses !== 0) begin fails++; $display("FAIL rst_nopop: got %0d pops want 0", ren_pulses); end
  endtask

  task automatic test_stream();
    int  p0;
    logic ok;
    p0 = ren_pulses; ok = 1'b0;
    bus.out_ready = 1'b1;
    rst_n = 1'b1;
    for (int i = 0; i < 12 && !ok; i++) begin @(negedge clk); ok = bus.out_valid; end
    tests++; if (!ok) begin fails++; $display("FAIL stream_wait: out_valid got 0 want 1"); end
    tests++; if (bus.out_data !== 32'h04030201) begin fails++; $display("FAIL stream_data: got %h want 04030201", bus.out_data); end
    tests++; if (bus.out_keep !== 4'hF) begin fails++; $display("FAIL stream_keep: got %h want f", bus.out_keep); end
    tests++; if (ren_pulses - p0 !== 4) begin fails++; $display("FAIL stream_pops: got %0d want 4", ren_pulses - p0); end
    tests++; if (bus.fifo_ren !== 1'b0) begin fails++; $display("FAIL stream_hold_ren: got %b want 0", bus.fifo_ren); end
    @(negedge clk);
    exp_count = 1;
    bus.out_ready = 1'b0;
    tests++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL stream_drop: got %b want 0", bus.out_valid); end
    tests++; if (word_count !== 4'(exp_count)) begin fails++; $display("FAIL stream_count: got %0d want %0d", word_count, exp_count); end
  endtask

  task automatic test_empty_guard();
    int u0;
    u0 = underflows;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      flush = (i % 2 == 0);
      @(negedge clk);
      tests++; if (bus.fifo_ren !== 1'b0) begin fails++; $display("FAIL empty_ren[%0d]: got %b want 0", i, bus.fifo_ren); end
      tests++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL empty_valid[%0d]: got %b want 0", i, bus.out_valid); end
    end
    flush = 1'b0; bus.out_ready = 1'b0;
    tests++; if (underflows !== u0) begin fails++; $display("FAIL empty_underflow: got %0d want %0d", underflows, u0); end
    tests++; if (word_count !== 4'(exp_count)) begin fails++; $display("FAIL empty_count: got %0d want %0d", word_count, exp_count); end
  endtask

  task automatic test_partial_flush();
    int  p0;
    logic ok;
    // flush after both pops have landed
    p0 = ren_pulses;
    push(8'hAA); push(8'hBB);
    for (int i = 0; i < 6 && (ren_pulses - p0) < 2; i++) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 4 && !ok; i++) begin ok = bus.out_valid; if (!ok) @(negedge clk); end
    tests++; if (!ok) begin fails++; $display("FAIL flush_wait: out_valid got 0 want 1"); end
    tests++; if (bus.out_data !== 32'h0000BBAA) begin fails++; $display("FAIL flush_data: got %h want 0000bbaa", bus.out_data); end
    tests++; if (bus.out_keep !== 4'h3) begin fails++; $display("FAIL flush_keep: got %h want 3", bus.out_keep); end
    accept();
    tests++; if (bus.out_data !== 32'h0 || bus.out_keep !== 4'h0) begin fails++; $display("FAIL flush_clear: got %h/%h want 0/0", bus.out_data, bus.out_keep); end
    tests++; if (word_count !== 4'(exp_count)) begin fails++; $display("FAIL flush_count: got %0d want %0d", word_count, exp_count); end
    // flush sampled at the same edge as the pop of the second byte
    push(8'hAA); push(8'hBB);
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    tests++; if (bus.out_valid !== 1'b1) begin fails++; $display("FAIL flush_same_valid: got %b want 1", bus.out_valid); end
    tests++; if (bus.out_data !== 32'h0000BBAA) begin fails++; $display("FAIL flush_same_data: got %h want 0000bbaa", bus.out_data); end
    tests++; if (bus.out_keep !== 4'h3) begin fails++; $display("FAIL flush_same_keep: got %h want 3", bus.out_keep); end
    accept();
    // single byte flushed in its pop cycle
    push(8'hCC);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    tests++; if (bus.out_valid !== 1'b1) begin fails++; $display("FAIL flush_one_valid: got %b want 1", bus.out_valid); end
    tests++; if (bus.out_data !== 32'h000000CC) begin fails++; $display("FAIL flush_one_data: got %h want 000000cc", bus.out_data); end
    tests++; if (bus.out_keep !== 4'h1) begin fails++; $display("FAIL flush_one_keep: got %h want 1", bus.out_keep); end
    accept();
  endtask

  task automatic test_backpressure();
    int  p0, p1;
    logic ok;
    p0 = ren_pulses; ok = 1'b0;
    bus.out_ready = 1'b0;
    push(8'h11); push(8'h22); push(8'h33); push(8'h44);
    push(8'h55); push(8'h66); push(8'h77);
    for (int i = 0; i < 8 && !ok; i++) begin @(negedge clk); ok = bus.out_valid; end
    tests++; if (!ok) begin fails++; $display("FAIL bp_wait: out_valid got 0 want 1"); end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      tests++; if (bus.out_valid !== 1'b1 || bus.out_data !== 32'h44332211 || bus.fifo_ren !== 1'b0)
        begin fails++; $display("FAIL bp_stall[%0d]: got v=%b d=%h ren=%b want v=1 d=44332211 ren=0", i, bus.out_valid, bus.out_data, bus.fifo_ren); end
    end
    p1 = ren_pulses;
    tests++; if (p1 - p0 !== 4) begin fails++; $display("FAIL bp_pops: got %0d want 4", p1 - p0); end
    accept();
    tests++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL bp_drop: got %b want 0", bus.out_valid); end
    for (int i = 0; i < 3; i++) begin
      tests++; if (bus.fifo_ren !== 1'b1) begin fails++; $display("FAIL bp_resume[%0d]: ren got %b want 1", i, bus.fifo_ren); end
      @(negedge clk);
    end
    tests++; if (ren_pulses - p1 !== 3 || bus.fifo_ren !== 1'b0) begin fails++; $display("FAIL bp_resume_pops: got %0d ren=%b want 3 ren=0", ren_pulses - p1, bus.fifo_ren); end
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    tests++; if (bus.out_data !== 32'h00776655 || bus.out_keep !== 4'h7) begin fails++; $display("FAIL bp_tail: got %h/%h want 00776655/7", bus.out_data, bus.out_keep); end
    accept();
  endtask

  task automatic test_reset_mid();
    int  p0;
    logic ok;
    // reset after two pops of a word
    p0 = ren_pulses;
    bus.out_ready = 1'b0;
    push(8'hA1); push(8'hA2); push(8'hA3); push(8'hA4);
    for (int i = 0; i < 6 && (ren_pulses - p0) < 2; i++) @(negedge clk);
    rst_n = 1'b0;
    #1;
    exp_count = 0;
    tests++; if (bus.out_valid !== 1'b0 || bus.out_data !== 32'h0 || bus.out_keep !== 4'h0 || bus.fifo_ren !== 1'b0)
      begin fails++; $display("FAIL midrst_fill: got v=%b d=%h k=%h ren=%b want all 0", bus.out_valid, bus.out_data, bus.out_keep, bus.fifo_ren); end
    tests++; if (word_count !== 4'h0) begin fails++; $display("FAIL midrst_fill_count: got %0d want 0", word_count); end
    @(negedge clk);
    rst_n = 1'b1;
    push(8'hB1); push(8'hB2);
    ok = 1'b0;
    for (int i = 0; i < 8 && !ok; i++) begin @(negedge clk); ok = bus.out_valid; end
    tests++; if (!ok || bus.out_data !== 32'hB2B1A4A3 || bus.out_keep !== 4'hF)
      begin fails++; $display("FAIL midrst_fill_next: got v=%b d=%h k=%h want 1 b2b1a4a3 f", ok, bus.out_data, bus.out_keep); end
    accept();
    // reset while holding a finished word
    push(8'hC1); push(8'hC2); push(8'hC3); push(8'hC4);
    ok = 1'b0;
    for (int i = 0; i < 8 && !ok; i++) begin @(negedge clk); ok = bus.out_valid; end
    tests++; if (!ok) begin fails++; $display("FAIL midrst_hold_wait: out_valid got 0 want 1"); end
    rst_n = 1'b0;
    #1;
    exp_count = 0;
    tests++; if (bus.out_valid !== 1'b0 || bus.out_data !== 32'h0 || bus.out_keep !== 4'h0 || word_count !== 4'h0)
      begin fails++; $display("FAIL midrst_hold: got v=%b d=%h k=%h c=%0d want all 0", bus.out_valid, bus.out_data, bus.out_keep, word_count); end
    @(negedge clk);
    rst_n = 1'b1;
    push(8'hD1); push(8'hD2); push(8'hD3); push(8'hD4);
    ok = 1'b0;
    for (int i = 0; i < 8 && !ok; i++) begin @(negedge clk); ok = bus.out_valid; end
    tests++; if (!ok || bus.out_data !== 32'hD4D3D2D1) begin fails++; $display("FAIL midrst_hold_next: got v=%b d=%h want 1 d4d3d2d1", ok, bus.out_data); end
    accept();
    tests++; if (word_count !== 4'h1) begin fails++; $display("FAIL midrst_count: got %0d want 1", word_count); end
  endtask

  task automatic test_counter_wrap();
    int  p0, acc;
    logic [31:0] exp_word;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    exp_count = 0;
    p0 = ren_pulses; acc = 0;
    for (int w = 0; w < 17; w++)
      for (int k = 0; k < 4; k++) push(8'(w * 4 + k));
    bus.out_ready = 1'b1;
    for (int i = 0; i < 200 && acc < 17; i++) begin
      @(negedge clk);
      if (bus.out_valid) begin
        exp_word = {8'(acc * 4 + 3), 8'(acc * 4 + 2), 8'(acc * 4 + 1), 8'(acc * 4)};
        tests++; if (bus.out_data !== exp_word) begin fails++; $display("FAIL wrap_word[%0d]: got %h want %h", acc, bus.out_data, exp_word); end
        acc++;
      end
    end
    tests++; if (acc != 17) begin fails++; $display("FAIL wrap_wait: got %0d words want 17", acc); end
    @(negedge clk);
    bus.out_ready = 1'b0;
    tests++; if (word_count !== 4'h1) begin fails++; $display("FAIL wrap_count: got %0d want 1", word_count); end
    tests++; if (ren_pulses - p0 !== 68) begin fails++; $display("FAIL wrap_pops: got %0d want 68", ren_pulses - p0); end
    tests++; if (underflows !== 0) begin fails++; $display("FAIL underflow: got %0d want 0", underflows); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_stream();
    test_empty_guard();
    test_partial_flush();
    test_backpressure();
    test_reset_mid();
    test_counter_wrap();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fifo_drain.md
# fifo_drain

Read-side consumer for the 8-bit byte FIFO. It pops bytes from the FIFO's async-read head, packs them little-endian into `BYTES_PER_WORD`-byte words, and presents each word on a valid/ready output stream with a byte-keep mask. A `flush` input emits a partially filled word. It is the only agent driving the FIFO's `ren`, and it never reads while the FIFO is empty, so the FIFO's underflow write-skip path is never exercised.

## Interface
- `BYTES_PER_WORD`, 4: bytes per output word, legal range 2..8.
- `CNT_BITS`, 16: width of the `word_count` counter.
- `clk`  in  1  single clock; all state changes on the posedge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `fifo_empty`  in  1  FIFO empty flag.
- `fifo_rdata`  in  8  FIFO head byte; combinational, valid in the same cycle whenever `!fifo_empty`.
- `fifo_ren`  out  1  pop strobe; the FIFO consumes the head at the posedge where this is high.
- `flush`  in  1  request to emit the current partial word.
- `out_valid`  out  1  output word valid.
- `out_ready`  in  1  downstream accept.
- `out_data`  out  8*BYTES_PER_WORD  packed word; byte k is at bits [8k+7:8k].
- `out_keep`  out  BYTES_PER_WORD  bit k set means byte k holds FIFO data.
- `word_count`  out  CNT_BITS  number of words accepted downstream since reset; wraps to 0.

## Operation
- State machine with two states: FILL and HOLD. A byte index `idx` runs 0..BYTES_PER_WORD-1.
- FILL:
  - `fifo_ren = rst_n && !fifo_empty`. This is combinational and is never high while `fifo_empty` is high or while in reset.
  - On a pop, `fifo_rdata` is written to lane `idx`, `out_keep[idx]` is set, and `idx` increments.
  - A pop into lane BYTES_PER_WORD-1 moves the block to HOLD.
  - `flush`=1 with at least one byte held after this cycle's pop (`idx>0`, or a pop this cycle) moves the block to HOLD. Any byte popped in the same cycle is included.
  - `flush` with no bytes held and no pop this cycle is ignored and is not remembered.
- HOLD:
  - `out_valid`=1 and `fifo_ren`=0. `flush` is ignored.
  - `out_data` and `out_keep` are stable until accepted.
  - On `out_valid && out_ready`: `out_data` and `out_keep` clear to 0, `idx` clears to 0, `word_count` increments (modulo 2^CNT_BITS), and the block returns to FILL.
- Unused lanes of a flushed word read 0, and their keep bits are 0. A full word has all keep bits set.
- Reset, asynchronous and possible mid-word or mid-HOLD: any partial or pending word is discarded.

## Timing
- Reset values: `out_valid`=0, `out_data`=0, `out_keep`=0, `word_count`=0, `fifo_ren`=0. The block comes out of reset in FILL with `idx`=0.
- Latency: a last byte popped at edge N gives `out_valid`=1 in the cycle after N. A `flush` sampled at edge N gives the same.
- No pops occur in HOLD. The first pop of the next word can happen in the cycle after the accepting edge, so each word costs at least BYTES_PER_WORD+1 cycles: one bubble per word.
- `out_valid`, `out_data` and `out_keep` are registered. `fifo_ren` is the only combinational output.
- Handshake: once `out_valid` rises it stays high until the cycle in which `out_ready`=1. There is no combinational path from `out_ready` to any output.

## Test plan
- Reset then stream: release `rst_n`, preload the FIFO with 01,02,03,04 and hold `out_ready`=1 -> exactly 4 `fifo_ren` pulses, then `out_valid` with `out_data`=0x04030201 and `out_keep`=0xF; `word_count` goes to 1 after the accept.
- Empty guard: FIFO empty for 20 cycles with `flush` toggling -> `fifo_ren`=0 and `out_valid`=0 throughout; the FIFO's `wskip` never fires.
- Partial flush: push AA,BB, then pulse `flush` after both pops -> `out_data`=0x0000BBAA, `out_keep`=0x3. Repeat with `flush` asserted in the same cycle as the pop of BB -> identical result.
- Backpressure: complete a word with `out_ready`=0 for 10 cycles while the FIFO holds 3 more bytes -> `out_valid` and data stable, no `fifo_ren` during the stall; after accept, the 3 bytes pop on consecutive cycles.
- Reset mid-operation: after 2 pops, and separately while in HOLD, pulse `rst_n` low -> all outputs return to 0 immediately; the next word starts at lane 0 and the discarded bytes never appear.
- Counter wrap with CNT_BITS=4: complete 17 words -> `word_count` reads 1. Formal: assert `!(fifo_ren && fifo_empty)`, assert `out_valid` stability under `!out_ready`, cover a flushed word with `out_keep`=0x1.
